multi_ch_stream_packer: RTL and testbench
=========================================

Name: multi_ch_stream_packer

Overview:
- Parameterised N-channel successor to the fixed six-channel TDC/MEMS FIFO path.
- Each channel pushes data words plus new-line and new-frame markers into its own FIFO.
- A round-robin arbiter drains the FIFOs into a framed byte stream for the UART serial transmitter.
- Sits between the per-channel producers (tdc_control / fake_tdc, mems_control / fake_mems) and serial_tx.

Parameters:
- NUM_CH, 6, number of channels (1..64).
- DATA_W, 16, payload bits per data word; multiple of 8.
- FIFO_WIDTH, 7, log2 of per-channel FIFO depth (depth 128).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- ch_wr_en  in  NUM_CH  per-channel data write request, level, held until ch_wr_done.
- ch_din  in  NUM_CH*DATA_W  channel c payload at bits [c*DATA_W +: DATA_W].
- ch_new_line  in  NUM_CH  line-marker request, level.
- ch_new_frame  in  NUM_CH  frame-marker request, level.
- ch_wr_done  out  NUM_CH  1-cycle acknowledge for a data write.
- ch_line_done  out  NUM_CH  1-cycle acknowledge for a line marker.
- ch_frame_done  out  NUM_CH  1-cycle acknowledge for a frame marker.
- ch_overflow  out  NUM_CH  sticky flag: an entry was dropped because the FIFO was full.
- tx_data  out  8  byte to serial_tx.
- new_tx_data  out  1  1-cycle strobe qualifying tx_data.
- tx_busy  in  1  serial_tx busy.

Behaviour:
- Reset: all FIFOs emptied, arbiter pointer = 0, FSM = IDLE. All outputs are 0, including ch_overflow.
- FIFO entry: {type[1:0], payload[DATA_W-1:0]}. Type codes: DATA=00, LINE=01, FRAME=10.
- Write side, per channel, per cycle:
  - At most one request is accepted. Priority: FRAME > LINE > DATA.
  - A request is accepted only if armed. Accepting it disarms it; it re-arms once seen low.
  - The matching done pulse is asserted the cycle after acceptance.
  - If the FIFO is full, the entry is dropped, ch_overflow[c] is set, and the done pulse still fires, so producers never deadlock.
- Read side FSM:
  - IDLE: if any FIFO is non-empty, go to ARB.
  - ARB: choose the first non-empty channel starting at (last_served+1) mod NUM_CH. Issue a pop, go to LOAD.
  - LOAD: FIFO read latency is 1. Latch the entry, update last_served, go to HDR.
  - HDR: send header byte {type, ch_id[5:0]}. DATA goes to PAY; LINE and FRAME go to DONE.
  - PAY: send DATA_W/8 payload bytes, MSB first.
  - DONE: go to IDLE.
- Byte send rule:
  - new_tx_data pulses only when tx_busy=0.
  - The following cycle is a mandatory gap cycle, because tx_busy rises one cycle late.
  - Then wait for tx_busy=0 before the next byte.
- Simultaneous push and pop on the same FIFO are both honoured; the count is unchanged. Pop from empty never occurs.
- Pointers wrap modulo 2^FIFO_WIDTH. The count is FIFO_WIDTH+1 bits wide.
- Reset during a packet abandons the packet immediately; the bytes already sent are not completed.

Optional Feature:
- Macro: PKT_CHECKSUM_EN.
- Defined: after the last byte of every packet (header-only or data), one extra byte is sent. It is the XOR of all bytes of that packet, sent via an extra CSUM state before DONE.
- Undefined: no trailer. Packet length is 1 byte for markers and 1+DATA_W/8 bytes for data.

Decomposition:
- Package multi_ch_stream_pkg holds:
  - the type codes DATA/LINE/FRAME;
  - the FSM state enum (IDLE, ARB, LOAD, HDR, PAY, CSUM, DONE);
  - the header bit-field positions.
- Sub-module sync_fifo (width DATA_W+2, depth 2^FIFO_WIDTH, registered read, full/empty/count outputs), instantiated NUM_CH times via generate.

Test Plan:
- Reset check: NUM_CH=6, DATA_W=16. Channel 2 writes 0xBEEF, tx_busy held 0. Expected output: bytes 0x02, 0xBE, 0xEF. ch_wr_done[2] pulses exactly once, 1 cycle after acceptance.
- Round-robin: channels 0, 3 and 5 each hold one data word; last_served=3. Headers must appear in the order 0x05, 0x00, 0x03.
- Markers and priority: channel 1 raises new_frame and new_line in the same cycle. Expected bytes 0x81 then 0x41. ch_frame_done[1] is acknowledged one cycle before ch_line_done[1].
- Overflow: with tx_busy=1, push 129 words into channel 4. ch_overflow[4] rises on word 129 and all 129 ch_wr_done pulses occur. After tx_busy is released, exactly 128 packets are emitted.
- Handshake: tx_busy is 1 for 10 cycles after each strobe. There must be no new_tx_data while busy and at least one gap cycle between strobes. Assert rst mid-payload: the next cycle shows new_tx_data=0, and all FIFOs are empty.
- PKT_CHECKSUM_EN: data 0x1234 on channel 0. Expected bytes 0x00, 0x12, 0x34, 0x26.

Source files
------------

// File: rtl/multi_ch_stream_packer_pkg.sv
// Shared types for the multi-channel stream packer: FIFO entry type codes,
// read-side FSM states and the header byte layout.
package multi_ch_stream_pkg;

   typedef enum logic [1:0] {
      TYPE_DATA  = 2'b00,
      TYPE_LINE  = 2'b01,
      TYPE_FRAME = 2'b10
   } entry_type_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_LOAD,
      S_HDR,
      S_PAY,
      S_CSUM,
      S_DONE
   } state_t;

   localparam int HDR_TYPE_MSB = 7;
   localparam int HDR_TYPE_LSB = 6;
   localparam int HDR_CH_MSB   = 5;
   localparam int HDR_CH_LSB   = 0;

   function automatic logic [7:0] make_header(input entry_type_t t, input logic [5:0] ch);
      logic [7:0] h;
      h = '0;
      h[HDR_TYPE_MSB:HDR_TYPE_LSB] = t;
      h[HDR_CH_MSB:HDR_CH_LSB]     = ch;
      return h;
   endfunction

endpackage

// File: rtl/multi_ch_stream_packer_sync_fifo.sv
// Single-clock FIFO with registered read data (one cycle after pop).
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 18,
   parameter int AW    = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   localparam int DEPTH = 1 << AW;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = count[AW];
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage carries no reset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            dout   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/multi_ch_stream_packer.sv
// N-channel stream packer: per-channel FIFOs drained round-robin into framed
// bytes for serial_tx. Define PKT_CHECKSUM_EN to append an XOR trailer byte.
module multi_ch_stream_packer
   import multi_ch_stream_pkg::*;
#(
   parameter int NUM_CH     = 6,
   parameter int DATA_W     = 16,
   parameter int FIFO_WIDTH = 7
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        ch_wr_en,
   input  logic [NUM_CH*DATA_W-1:0] ch_din,
   input  logic [NUM_CH-1:0]        ch_new_line,
   input  logic [NUM_CH-1:0]        ch_new_frame,
   output logic [NUM_CH-1:0]        ch_wr_done,
   output logic [NUM_CH-1:0]        ch_line_done,
   output logic [NUM_CH-1:0]        ch_frame_done,
   output logic [NUM_CH-1:0]        ch_overflow,
   output logic [7:0]               tx_data,
   output logic                     new_tx_data,
   input  logic                     tx_busy
);

   localparam int ENT_W = DATA_W + 2;
   localparam int NB    = DATA_W / 8;
   localparam int BC_W  = $clog2(NB + 1);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

`ifdef PKT_CHECKSUM_EN
   localparam state_t AFTER_LAST = S_CSUM;
`else
   localparam state_t AFTER_LAST = S_DONE;
`endif

   // Write side
   logic [NUM_CH-1:0] frame_armed, line_armed, data_armed;
   logic [NUM_CH-1:0] acc_frame, acc_line, acc_data, acc_any;
   logic [NUM_CH-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [ENT_W-1:0]  fifo_din   [NUM_CH];
   logic [ENT_W-1:0]  fifo_dout  [NUM_CH];
   logic [FIFO_WIDTH:0] fifo_count [NUM_CH];

   // Read side
   state_t            state, state_next;
   logic [CH_W-1:0]   last_served;
   logic [CH_W-1:0]   sel;
   logic [CH_W-1:0]   arb_pick;
   entry_type_t       ent_type;
   logic [DATA_W-1:0] shreg;
   logic [BC_W-1:0]   byte_cnt;
   logic              gap;
   logic              can_send;
   logic              strobe;
   logic [7:0]        cur_byte;
`ifdef PKT_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   // FRAME beats LINE beats DATA; only armed requests can be taken.
   assign acc_frame = ch_new_frame & frame_armed;
   assign acc_line  = ch_new_line & line_armed & ~acc_frame;
   assign acc_data  = ch_wr_en & data_armed & ~acc_frame & ~acc_line;
   assign acc_any   = acc_frame | acc_line | acc_data;
   assign fifo_push = acc_any & ~fifo_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_armed   <= '1;
         line_armed    <= '1;
         data_armed    <= '1;
         ch_wr_done    <= '0;
         ch_line_done  <= '0;
         ch_frame_done <= '0;
         ch_overflow   <= '0;
      end else begin
         frame_armed   <= ~acc_frame & (frame_armed | ~ch_new_frame);
         line_armed    <= ~acc_line & (line_armed | ~ch_new_line);
         data_armed    <= ~acc_data & (data_armed | ~ch_wr_en);
         ch_wr_done    <= acc_data;
         ch_line_done  <= acc_line;
         ch_frame_done <= acc_frame;
         ch_overflow   <= ch_overflow | (acc_any & fifo_full);
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      always_comb begin
         fifo_din[c] = {TYPE_DATA, ch_din[c*DATA_W +: DATA_W]};
         if (acc_frame[c]) begin
            fifo_din[c] = {TYPE_FRAME, {DATA_W{1'b0}}};
         end else if (acc_line[c]) begin
            fifo_din[c] = {TYPE_LINE, {DATA_W{1'b0}}};
         end
      end

      sync_fifo #(
         .WIDTH (ENT_W),
         .AW    (FIFO_WIDTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (fifo_push[c]),
         .din   (fifo_din[c]),
         .pop   (fifo_pop[c]),
         .dout  (fifo_dout[c]),
         .full  (fifo_full[c]),
         .empty (fifo_empty[c]),
         .count (fifo_count[c])
      );

      always_ff @(posedge clk) begin
         if (!rst) begin
            assert (((fifo_count[c] == '0) == fifo_empty[c]) &&
                    (fifo_count[c][FIFO_WIDTH] == fifo_full[c]));
         end
      end
   end

   function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] base, input int off);
      int s;
      s = int'(base) + 1 + off;
      if (s >= NUM_CH) begin
         s = s - NUM_CH;
      end
      return CH_W'(s);
   endfunction

   // Scan downwards so the nearest channel after last_served wins.
   always_comb begin
      arb_pick = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (!fifo_empty[rr_index(last_served, i)]) begin
            arb_pick = rr_index(last_served, i);
         end
      end
   end

   // serial_tx raises busy one cycle late, so a strobe is always followed by a gap.
   assign can_send = !gap && !tx_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      fifo_pop   = '0;
      strobe     = 1'b0;
      cur_byte   = '0;
      case (state)
         // Arbitration waits for an idle link so stalled entries stay queued.
         S_IDLE: begin
            if ((|(~fifo_empty)) && !tx_busy) begin
               state_next = S_ARB;
            end
         end
         S_ARB: begin
            fifo_pop[arb_pick] = 1'b1;
            state_next         = S_LOAD;
         end
         S_LOAD: begin
            state_next = S_HDR;
         end
         S_HDR: begin
            cur_byte = make_header(ent_type, 6'(last_served));
            if (can_send) begin
               strobe     = 1'b1;
               state_next = (ent_type == TYPE_DATA) ? S_PAY : AFTER_LAST;
            end
         end
         S_PAY: begin
            cur_byte = shreg[DATA_W-1 -: 8];
            if (can_send) begin
               strobe = 1'b1;
               if (byte_cnt == BC_W'(1)) begin
                  state_next = AFTER_LAST;
               end
            end
         end
         S_CSUM: begin
`ifdef PKT_CHECKSUM_EN
            cur_byte = csum;
            if (can_send) begin
               strobe     = 1'b1;
               state_next = S_DONE;
            end
`else
            state_next = S_DONE;
`endif
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_served <= '0;
         sel         <= '0;
         ent_type    <= TYPE_DATA;
         shreg       <= '0;
         byte_cnt    <= '0;
         gap         <= 1'b0;
      end else begin
         gap <= strobe;
         case (state)
            S_ARB: begin
               sel <= arb_pick;
            end
            S_LOAD: begin
               ent_type    <= entry_type_t'(fifo_dout[sel][ENT_W-1 -: 2]);
               shreg       <= fifo_dout[sel][DATA_W-1:0];
               byte_cnt    <= BC_W'(NB);
               last_served <= sel;
            end
            S_PAY: begin
               if (strobe) begin
                  shreg    <= shreg << 8;
                  byte_cnt <= byte_cnt - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef PKT_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst || state == S_LOAD) begin
         csum <= '0;
      end else if (strobe) begin
         csum <= csum ^ cur_byte;
      end
   end
`endif

   assign tx_data     = cur_byte;
   assign new_tx_data = strobe;

endmodule

// File: tb/tb_multi_ch_stream_packer.sv
// Directed bench for multi_ch_stream_packer: byte stream scoreboard, write
// handshakes, round-robin order, overflow, link handshake and reset abort.
`timescale 1ns/1ps
module tb_multi_ch_stream_packer;

   localparam int NUM_CH     = 6;
   localparam int DATA_W     = 16;
   localparam int FIFO_WIDTH = 7;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_CH-1:0]        ch_wr_en;
   logic [NUM_CH*DATA_W-1:0] ch_din;
   logic [NUM_CH-1:0]        ch_new_line;
   logic [NUM_CH-1:0]        ch_new_frame;
   logic [NUM_CH-1:0]        ch_wr_done;
   logic [NUM_CH-1:0]        ch_line_done;
   logic [NUM_CH-1:0]        ch_frame_done;
   logic [NUM_CH-1:0]        ch_overflow;
   logic [7:0]               tx_data;
   logic                     new_tx_data;
   logic                     tx_busy;

   logic       force_busy = 1'b0;
   logic       model_en   = 1'b0;
   int         busy_cnt   = 0;
   int         n_vec      = 0;
   int         n_err      = 0;
   int         hs_viol    = 0;
   logic       prev_strobe = 1'b0;
   int         wr_done_cnt [NUM_CH];
   logic [7:0] exp_q [$];
   logic [7:0] rx_q  [$];

   multi_ch_stream_packer #(
      .NUM_CH     (NUM_CH),
      .DATA_W     (DATA_W),
      .FIFO_WIDTH (FIFO_WIDTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ch_wr_en      (ch_wr_en),
      .ch_din        (ch_din),
      .ch_new_line   (ch_new_line),
      .ch_new_frame  (ch_new_frame),
      .ch_wr_done    (ch_wr_done),
      .ch_line_done  (ch_line_done),
      .ch_frame_done (ch_frame_done),
      .ch_overflow   (ch_overflow),
      .tx_data       (tx_data),
      .new_tx_data   (new_tx_data),
      .tx_busy       (tx_busy)
   );

   // Clock and serial_tx model: busy is seen from the second cycle after a strobe, for 10 cycles.
   always #10 clk = ~clk;

   always @(posedge clk) begin
      if (new_tx_data === 1'b1) busy_cnt <= 11;
      else if (busy_cnt != 0)   busy_cnt <= busy_cnt - 1;
   end

   assign tx_busy = force_busy || (model_en && busy_cnt >= 1 && busy_cnt <= 10);

   // Monitor
   always @(negedge clk) begin
      if (new_tx_data === 1'b1) begin
         rx_q.push_back(tx_data);
         if (tx_busy || prev_strobe) hs_viol++;
      end
      prev_strobe = (new_tx_data === 1'b1);
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_wr_done[c] === 1'b1) wr_done_cnt[c]++;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_data(input int c, input logic [DATA_W-1:0] v, input string tag);
      int lat;
      lat = 0;
      ch_din[c*DATA_W +: DATA_W] = v;
      ch_wr_en[c] = 1'b1;
      do begin
         tick();
         lat++;
      end while (ch_wr_done[c] !== 1'b1 && lat < 8);
      check({tag, " wr_done latency"}, lat, 1);
      ch_wr_en[c] = 1'b0;
      tick();
   endtask

   task automatic expect_data_pkt(input logic [7:0] hdr, input logic [DATA_W-1:0] pay);
      exp_q.push_back(hdr);
      exp_q.push_back(pay[15:8]);
      exp_q.push_back(pay[7:0]);
`ifdef PKT_CHECKSUM_EN
      exp_q.push_back(hdr ^ pay[15:8] ^ pay[7:0]);
`endif
   endtask

   task automatic expect_marker_pkt(input logic [7:0] hdr);
      exp_q.push_back(hdr);
`ifdef PKT_CHECKSUM_EN
      exp_q.push_back(hdr);
`endif
   endtask

   task automatic wait_bytes(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (rx_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      check({tag, " byte count"}, rx_q.size(), n);
   endtask

   task automatic score(input string tag);
      logic [7:0] e;
      logic [7:0] o;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (rx_q.size() != 0) o = rx_q.pop_front();
         else                  o = 8'hxx;
         check(tag, o, e);
      end
   endtask

   initial begin
      foreach (wr_done_cnt[c]) wr_done_cnt[c] = 0;
      rst          = 1'b1;
      ch_wr_en     = '0;
      ch_din       = '0;
      ch_new_line  = '0;
      ch_new_frame = '0;
      repeat (3) tick();

      check("rst new_tx_data", new_tx_data, 0);
      check("rst tx_data", tx_data, 0);
      check("rst wr_done", ch_wr_done, 0);
      check("rst line_done", ch_line_done, 0);
      check("rst frame_done", ch_frame_done, 0);
      check("rst overflow", ch_overflow, 0);
      rst = 1'b0;
      tick();

      // Single data word on channel 2, link idle
      push_data(2, 16'hBEEF, "t1");
      exp_q.push_back(8'h02);
      exp_q.push_back(8'hBE);
      exp_q.push_back(8'hEF);
`ifdef PKT_CHECKSUM_EN
      exp_q.push_back(8'h02 ^ 8'hBE ^ 8'hEF);
`endif
      wait_bytes(exp_q.size(), 200, "t1");
      score("t1 byte");
      check("t1 wr_done pulses", wr_done_cnt[2], 1);
      repeat (5) tick();

      // Round-robin after serving channel 3
      push_data(3, 16'h3333, "t2a");
      expect_data_pkt(8'h03, 16'h3333);
      wait_bytes(exp_q.size(), 200, "t2a");
      score("t2a byte");
      repeat (5) tick();
      force_busy = 1'b1;
      push_data(0, 16'h0A0A, "t2 ch0");
      push_data(3, 16'h3C3C, "t2 ch3");
      push_data(5, 16'h5A5A, "t2 ch5");
      check("t2 held while busy", rx_q.size(), 0);
      force_busy = 1'b0;
      expect_data_pkt(8'h05, 16'h5A5A);
      expect_data_pkt(8'h00, 16'h0A0A);
      expect_data_pkt(8'h03, 16'h3C3C);
      wait_bytes(exp_q.size(), 400, "t2");
      score("t2 byte");
      repeat (5) tick();

      // Frame and line requested together on channel 1
      ch_new_frame[1] = 1'b1;
      ch_new_line[1]  = 1'b1;
      tick();
      check("t3 frame_done first", ch_frame_done, 6'b000010);
      check("t3 line_done not yet", ch_line_done, 6'b000000);
      tick();
      check("t3 frame_done single", ch_frame_done, 6'b000000);
      check("t3 line_done second", ch_line_done, 6'b000010);
      ch_new_frame[1] = 1'b0;
      ch_new_line[1]  = 1'b0;
      tick();
      check("t3 line_done single", ch_line_done, 6'b000000);
      expect_marker_pkt(8'h81);
      expect_marker_pkt(8'h41);
      wait_bytes(exp_q.size(), 200, "t3");
      score("t3 byte");
      repeat (5) tick();

      // Overflow: 129 words into a 128-deep FIFO with the link stalled
      force_busy = 1'b1;
      for (int i = 0; i < 129; i++) begin
         push_data(4, 16'h4000 + 16'(i), "t4");
         if (i == 127) check("t4 no overflow at 128", ch_overflow, 6'b000000);
      end
      check("t4 overflow at 129", ch_overflow, 6'b010000);
      check("t4 wr_done pulses", wr_done_cnt[4], 129);
      check("t4 held while busy", rx_q.size(), 0);
      for (int i = 0; i < 128; i++) expect_data_pkt(8'h04, 16'h4000 + 16'(i));
      model_en   = 1'b1;
      force_busy = 1'b0;
      wait_bytes(exp_q.size(), 9000, "t4");
      score("t4 byte");
      repeat (60) tick();
      check("t4 no extra bytes", rx_q.size(), 0);
      check("t4 overflow sticky", ch_overflow, 6'b010000);

      // Handshake under a busy link, then reset mid-payload
      force_busy = 1'b1;
      push_data(0, 16'hA55A, "t5 ch0");
      push_data(2, 16'h1111, "t5 ch2");
      push_data(5, 16'h2222, "t5 ch5");
      force_busy = 1'b0;
      exp_q.push_back(8'h05);
      exp_q.push_back(8'h22);
      wait_bytes(2, 200, "t5 pre");
      score("t5 byte");
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("t5 rst strobe", new_tx_data, 0);
      check("t5 rst overflow", ch_overflow, 0);
      rst = 1'b0;
      repeat (100) tick();
      check("t5 fifos empty", rx_q.size(), 0);
      check("t5 handshake", hs_viol, 0);

      // Checksum vector (trailer only when the feature is built in)
      push_data(0, 16'h1234, "t6");
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h34);
`ifdef PKT_CHECKSUM_EN
      exp_q.push_back(8'h26);
`endif
      wait_bytes(exp_q.size(), 200, "t6");
      score("t6 byte");
      repeat (40) tick();
      check("t6 no extra bytes", rx_q.size(), 0);
      check("final handshake", hs_viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
